lcd1602_bus_responder: RTL and testbench

- Synthesizable responder for the HD44780/LCD1602 parallel write bus, i.e. the LCD end of the link driven by the LCD1602 controller.
- Samples rs/rw/enable/data and decodes instructions and data writes.
- Maintains a DDRAM mirror (80 B), a CGRAM mirror (64 x 5 b) and display-control state.
- Exposes registered read ports and status for an on-board VGA mirror of the LCD and for self-checking benches.

---
 rtl/lcd1602_pkg.sv | 81 ++++++++
 rtl/lcd1602_bus_sync.sv | 40 ++++
 rtl/lcd1602_bus_responder.sv | 197 +++++++++++++++++++
 tb/tb_lcd1602_bus_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus responder: opcodes, DDRAM map bounds,
// register-file struct and the address-counter stepping helpers.
package lcd1602_pkg;
  localparam int DDRAM_DEPTH = 80;
  localparam int CGRAM_DEPTH = 64;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Single-bit opcodes double as masks: the highest set bit selects the instruction.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNCSET = 8'h20;
  localparam logic [7:0] OP_SET_CG  = 8'h40;
  localparam logic [7:0] OP_SET_DD  = 8'h80;

  localparam logic [6:0] DD_L1_END  = 7'h27;
  localparam logic [6:0] DD_L2_BASE = 7'h40;
  localparam logic [6:0] DD_L2_END  = 7'h67;
  localparam logic [6:0] DD_1L_END  = 7'h4F;

  typedef enum logic [1:0] {ST_FILL, ST_IDLE, ST_NIB_LO} state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] data;
  } bus_t;

  typedef struct packed {
    logic [6:0] ac;
    logic       tgt_cg;
    logic       display_on;
    logic       cursor_on;
    logic       blink_on;
    logic       two_line;
    logic       mode_8bit;
    logic       inc_mode;
    logic       shift_mode;
    logic [5:0] display_shift;
    logic [7:0] last_cmd;
  } regs_t;

  localparam regs_t REGS_RST = '{ac: 7'd0, tgt_cg: 1'b0, display_on: 1'b0, cursor_on: 1'b0,
                                 blink_on: 1'b0, two_line: 1'b0, mode_8bit: 1'b1, inc_mode: 1'b1,
                                 shift_mode: 1'b0, display_shift: 6'd0, last_cmd: 8'd0};

  function automatic logic dd_valid(input logic [6:0] a, input logic two_line);
    if (two_line) return (a <= DD_L1_END) || (a >= DD_L2_BASE && a <= DD_L2_END);
    return a <= DD_1L_END;
  endfunction

  // Line 2 (0x40..0x67) lands right after line 1's 40 cells.
  function automatic logic [6:0] dd_index(input logic [6:0] a, input logic two_line);
    return (two_line && a >= DD_L2_BASE) ? a - 7'd24 : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic tgt_cg,
                                         input logic two_line, input logic inc);
    logic [6:0] r;
    r = inc ? a + 7'd1 : a - 7'd1;
    if (tgt_cg) r = {1'b0, r[5:0]};
    else if (two_line) begin
      if      ( inc && a == DD_L1_END)  r = DD_L2_BASE;
      else if ( inc && a == DD_L2_END)  r = 7'd0;
      else if (!inc && a == 7'd0)       r = DD_L2_END;
      else if (!inc && a == DD_L2_BASE) r = DD_L1_END;
    end else begin
      if      ( inc && a == DD_1L_END)  r = 7'd0;
      else if (!inc && a == 7'd0)       r = DD_1L_END;
    end
    return r;
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic inc);
    if (inc) return (s == 6'd39) ? 6'd0 : s + 6'd1;
    return (s == 6'd0) ? 6'd39 : s - 6'd1;
  endfunction
endpackage

// File: rtl/lcd1602_bus_sync.sv
// Bus-input synchronizer with enable falling-edge detect; emits a one-cycle
// capture strobe together with the rs/rw/data sampled alongside that edge.
module lcd1602_bus_sync
  import lcd1602_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_enable,
  input  logic [7:0] lcd_data,
  output logic       cap,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);
  bus_t sync_q [SYNC_STAGES];
  logic en_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_d     <= 1'b0;
      cap      <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      sync_q[0] <= '{rs: lcd_rs, rw: lcd_rw, en: lcd_enable, data: lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_d     <= sync_q[SYNC_STAGES-1].en;
      cap      <= en_d & ~sync_q[SYNC_STAGES-1].en;
      cap_rs   <= sync_q[SYNC_STAGES-1].rs;
      cap_rw   <= sync_q[SYNC_STAGES-1].rw;
      cap_data <= sync_q[SYNC_STAGES-1].data;
    end
  end
endmodule

// File: rtl/lcd1602_bus_responder.sv
// LCD end of an HD44780 write bus: decodes instructions/data into DDRAM/CGRAM
// mirrors and display state, with emulated busy timing and error pulses.
module lcd1602_bus_responder
  import lcd1602_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_enable,
  input  logic [7:0] lcd_data,
  input  logic [6:0] dd_rd_addr,
  output logic [7:0] dd_rd_data,
  input  logic [5:0] cg_rd_addr,
  output logic [4:0] cg_rd_data,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       mode_8bit,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic [5:0] display_shift,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       char_strobe,
  output logic [7:0] last_cmd,
  output logic       timing_err,
  output logic       bus_err,
  output logic       addr_err
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  logic       cap, cap_rs, cap_rw;
  logic [7:0] cap_data;

  lcd1602_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable),
    .lcd_data(lcd_data), .cap(cap), .cap_rs(cap_rs), .cap_rw(cap_rw), .cap_data(cap_data)
  );

  state_t        state, state_nx;
  regs_t         r, r_nx;
  logic [6:0]    fill_idx, fill_nx;
  logic [3:0]    hi_nib, hi_nx;
  logic [CW-1:0] busy_cnt, busy_nx;
  logic          cmd_nx, char_nx, terr_nx, berr_nx, aerr_nx;
  logic          do_byte, rs_v;
  logic [7:0]    byte_v;
  logic          dd_we, cg_we;
  logic [6:0]    dd_wa;
  logic [7:0]    dd_wd;
  logic [7:0]    dd_mem [DDRAM_DEPTH];
  logic [4:0]    cg_mem [CGRAM_DEPTH];

  always_comb begin
    state_nx = state;
    r_nx     = r;
    fill_nx  = fill_idx;
    hi_nx    = hi_nib;
    busy_nx  = (busy_cnt != '0) ? busy_cnt - 1'b1 : '0;
    cmd_nx   = 1'b0;
    char_nx  = 1'b0;
    terr_nx  = 1'b0;
    berr_nx  = 1'b0;
    aerr_nx  = 1'b0;
    do_byte  = 1'b0;
    rs_v     = cap_rs;
    byte_v   = cap_data;
    dd_we    = 1'b0;
    dd_wa    = fill_idx;
    dd_wd    = BLANK_CHAR;
    cg_we    = 1'b0;

    if (state == ST_FILL) begin
      dd_we   = 1'b1;
      fill_nx = fill_idx + 7'd1;
      if (fill_idx == 7'(DDRAM_DEPTH - 1)) state_nx = ST_IDLE;
      if (cap && cap_rw) berr_nx = 1'b1;
      else if (cap) begin
        terr_nx = 1'b1;
        // Only an 8-bit clear is honoured mid-fill; everything else is dropped.
        do_byte = r.mode_8bit && !cap_rs && cap_data == OP_CLEAR;
      end
    end else if (cap && cap_rw) begin
      berr_nx = 1'b1;
    end else if (cap) begin
      terr_nx = busy_cnt != '0;
      if (!r.mode_8bit && state == ST_IDLE) begin
        hi_nx    = cap_data[7:4];
        state_nx = ST_NIB_LO;
      end else begin
        do_byte  = 1'b1;
        state_nx = ST_IDLE;
        if (!r.mode_8bit) byte_v = {hi_nib, cap_data[7:4]};
      end
    end

    if (do_byte) begin
      busy_nx = CW'(BUSY_CYCLES);
      if (!rs_v) begin
        cmd_nx     = 1'b1;
        r_nx.last_cmd = byte_v;
        if (|(byte_v & OP_SET_DD)) begin
          r_nx.ac     = byte_v[6:0];
          r_nx.tgt_cg = 1'b0;
          aerr_nx     = !dd_valid(byte_v[6:0], r.two_line);
        end else if (|(byte_v & OP_SET_CG)) begin
          r_nx.ac     = {1'b0, byte_v[5:0]};
          r_nx.tgt_cg = 1'b1;
        end else if (|(byte_v & OP_FUNCSET)) begin
          r_nx.mode_8bit = byte_v[4];
          r_nx.two_line  = byte_v[3];
        end else if (|(byte_v & OP_SHIFT)) begin
          if (byte_v[3]) r_nx.display_shift = shift_step(r.display_shift, byte_v[2]);
          else           r_nx.ac = ac_step(r.ac, r.tgt_cg, r.two_line, byte_v[2]);
        end else if (|(byte_v & OP_DISPCTL)) begin
          {r_nx.display_on, r_nx.cursor_on, r_nx.blink_on} = byte_v[2:0];
        end else if (|(byte_v & OP_ENTRY)) begin
          r_nx.inc_mode   = byte_v[1];
          r_nx.shift_mode = byte_v[0];
        end else if (|(byte_v & (OP_HOME | OP_CLEAR))) begin
          r_nx.ac            = 7'd0;
          r_nx.tgt_cg        = 1'b0;
          r_nx.display_shift = 6'd0;
          busy_nx            = CW'(CLEAR_CYCLES);
          if (!byte_v[1]) begin
            r_nx.inc_mode = 1'b1;
            state_nx      = ST_FILL;
            fill_nx       = 7'd0;
          end
        end
      end else begin
        char_nx = 1'b1;
        if (r.tgt_cg) cg_we = 1'b1;
        else if (dd_valid(r.ac, r.two_line)) begin
          dd_we = 1'b1;
          dd_wa = dd_index(r.ac, r.two_line);
          dd_wd = byte_v;
        end else aerr_nx = 1'b1;
        r_nx.ac = ac_step(r.ac, r.tgt_cg, r.two_line, r.inc_mode);
        if (r.shift_mode) r_nx.display_shift = shift_step(r.display_shift, r.inc_mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FILL;
      r           <= REGS_RST;
      fill_idx    <= 7'd0;
      hi_nib      <= 4'd0;
      busy_cnt    <= '0;
      cmd_strobe  <= 1'b0;
      char_strobe <= 1'b0;
      timing_err  <= 1'b0;
      bus_err     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      r           <= r_nx;
      fill_idx    <= fill_nx;
      hi_nib      <= hi_nx;
      busy_cnt    <= busy_nx;
      cmd_strobe  <= cmd_nx;
      char_strobe <= char_nx;
      timing_err  <= terr_nx;
      bus_err     <= berr_nx;
      addr_err    <= aerr_nx;
    end
  end

  // Memories are not reset; the FILL pass blanks DDRAM, CGRAM keeps its contents.
  always_ff @(posedge clk) begin
    if (dd_we) dd_mem[dd_wa] <= dd_wd;
    if (cg_we) cg_mem[r.ac[5:0]] <= byte_v[4:0];
    dd_rd_data <= (dd_rd_addr < 7'(DDRAM_DEPTH)) ? dd_mem[dd_rd_addr] : BLANK_CHAR;
    cg_rd_data <= cg_mem[cg_rd_addr];
  end

  assign ac            = r.ac;
  assign display_on    = r.display_on;
  assign cursor_on     = r.cursor_on;
  assign blink_on      = r.blink_on;
  assign two_line      = r.two_line;
  assign mode_8bit     = r.mode_8bit;
  assign inc_mode      = r.inc_mode;
  assign shift_mode    = r.shift_mode;
  assign display_shift = r.display_shift;
  assign last_cmd      = r.last_cmd;
  assign busy          = (busy_cnt != '0) || (state == ST_FILL);
endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// Bench for lcd1602_bus_responder: directed scenarios plus a randomized
// instruction/data stream checked against an array-based LCD model.
module tb_lcd1602_bus_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_enable = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [6:0] dd_rd_addr = 7'd0;
  logic [7:0] dd_rd_data;
  logic [5:0] cg_rd_addr = 6'd0;
  logic [4:0] cg_rd_data;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on, two_line, mode_8bit, inc_mode, shift_mode;
  logic [5:0] display_shift;
  logic       busy, cmd_strobe, char_strobe, timing_err, bus_err, addr_err;
  logic [7:0] last_cmd;

  lcd1602_bus_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(150), .CLEAR_CYCLES(300)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable),
    .lcd_data(lcd_data), .dd_rd_addr(dd_rd_addr), .dd_rd_data(dd_rd_data),
    .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data), .ac(ac), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line), .mode_8bit(mode_8bit),
    .inc_mode(inc_mode), .shift_mode(shift_mode), .display_shift(display_shift), .busy(busy),
    .cmd_strobe(cmd_strobe), .char_strobe(char_strobe), .last_cmd(last_cmd),
    .timing_err(timing_err), .bus_err(bus_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int c_cmd = 0, c_char = 0, c_terr = 0, c_berr = 0, c_aerr = 0;
  int e_cmd = 0, e_char = 0, e_aerr = 0;

  always @(negedge clk) begin
    if (cmd_strobe  === 1'b1) c_cmd++;
    if (char_strobe === 1'b1) c_char++;
    if (timing_err  === 1'b1) c_terr++;
    if (bus_err     === 1'b1) c_berr++;
    if (addr_err    === 1'b1) c_aerr++;
  end

  // Model of the visible LCD: DDRAM as 80 linear cells, lines of 40 at 0x00/0x40.
  logic [7:0] m_dd [80];
  logic [4:0] m_cg [64];
  bit         m_cg_ok [64];
  int         m_ac = 0, m_shift = 0;
  bit         m_cg_tgt = 0, m_disp = 0, m_cur = 0, m_blink = 0, m_two = 0;
  bit         m_8bit = 1, m_inc = 1, m_smode = 0;
  logic [7:0] m_last = 8'h00;

  function automatic int dd_to_idx(input int a);
    if (m_two) return (a / 64 < 2 && a % 64 < 40) ? (a / 64) * 40 + a % 64 : -1;
    return (a < 80) ? a : -1;
  endfunction

  function automatic int ac_move(input bit up);
    int i;
    if (m_cg_tgt) return (m_ac + (up ? 1 : 63)) % 64;
    i = dd_to_idx(m_ac);
    if (i < 0) return (m_ac + (up ? 1 : 127)) % 128;
    i = (i + (up ? 1 : 79)) % 80;
    return m_two ? (i / 40) * 64 + i % 40 : i;
  endfunction

  task automatic model_apply(input bit rs, input logic [7:0] b);
    if (rs) begin
      e_char++;
      if (m_cg_tgt) begin m_cg[m_ac % 64] = b[4:0]; m_cg_ok[m_ac % 64] = 1; end
      else if (dd_to_idx(m_ac) >= 0) m_dd[dd_to_idx(m_ac)] = b;
      else e_aerr++;
      m_ac = ac_move(m_inc);
      if (m_smode) m_shift = (m_shift + (m_inc ? 1 : 39)) % 40;
    end else begin
      e_cmd++;
      m_last = b;
      if (b[7]) begin m_ac = int'(b[6:0]); m_cg_tgt = 0; if (dd_to_idx(m_ac) < 0) e_aerr++; end
      else if (b[6]) begin m_ac = int'(b[5:0]); m_cg_tgt = 1; end
      else if (b[5]) begin m_8bit = b[4]; m_two = b[3]; end
      else if (b[4]) begin
        if (b[3]) m_shift = (m_shift + (b[2] ? 1 : 39)) % 40;
        else m_ac = ac_move(b[2]);
      end
      else if (b[3]) begin m_disp = b[2]; m_cur = b[1]; m_blink = b[0]; end
      else if (b[2]) begin m_inc = b[1]; m_smode = b[0]; end
      else if (b[1]) begin m_ac = 0; m_shift = 0; m_cg_tgt = 0; end
      else if (b[0]) begin
        m_ac = 0; m_shift = 0; m_cg_tgt = 0; m_inc = 1;
        for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
      end
    end
  endtask

  task automatic bus_write(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    lcd_enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    if (m_8bit) bus_write(rs, 1'b0, b);
    else begin
      bus_write(rs, 1'b0, {b[7:4], 4'($urandom)});
      bus_write(rs, 1'b0, {b[3:0], 4'($urandom)});
    end
    model_apply(rs, b);
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wait_ready: busy=%b after %0d cycles, required 0", busy, n);
    else n_pass++;
  endtask

  task automatic read_dd(input int i, output logic [7:0] v);
    @(negedge clk); dd_rd_addr = 7'(i);
    @(negedge clk); v = dd_rd_data;
  endtask

  task automatic read_cg(input int i, output logic [4:0] v);
    @(negedge clk); cg_rd_addr = 6'(i);
    @(negedge clk); v = cg_rd_data;
  endtask

  task automatic test_reset;
    int n, bad;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, ac, mode_8bit, inc_mode, display_on, last_cmd, display_shift} !== {1'b1, 7'd0, 1'b1, 1'b1, 1'b0, 8'd0, 6'd0})
      $display("FAIL reset_state: busy=%b ac=%h m8=%b inc=%b don=%b last=%h sh=%0d", busy, ac, mode_8bit, inc_mode, display_on, last_cmd, display_shift);
    else n_pass++;
    reset = 1'b0;
    n = busy ? 1 : 0;
    for (int i = 0; i < 300 && busy === 1'b1; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    n_checks++;
    if (n != 80) $display("FAIL fill_busy_cycles: got %0d, required 80", n); else n_pass++;
    bad = 0;
    for (int i = 0; i < 80; i++) begin read_dd(i, v); if (v !== 8'h20) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL fill_blank: %0d cells differ from 0x20", bad); else n_pass++;
  endtask

  task automatic test_food;
    logic [7:0] v [4];
    send_byte(0, 8'h38); wait_ready;
    send_byte(0, 8'h0C); wait_ready;
    send_byte(0, 8'h01); wait_ready;
    send_byte(0, 8'h84); wait_ready;
    send_byte(1, "F"); wait_ready;
    send_byte(1, "O"); wait_ready;
    send_byte(1, "O"); wait_ready;
    send_byte(1, "D"); wait_ready;
    for (int i = 0; i < 4; i++) read_dd(4 + i, v[i]);
    n_checks++;
    if ({v[0], v[1], v[2], v[3]} !== 32'h464F4F44)
      $display("FAIL food_text: got %h %h %h %h, required 46 4F 4F 44", v[0], v[1], v[2], v[3]);
    else n_pass++;
    n_checks++;
    if ({two_line, display_on, ac} !== {1'b1, 1'b1, 7'h08})
      $display("FAIL food_regs: two_line=%b display_on=%b ac=%h, required 1 1 08", two_line, display_on, ac);
    else n_pass++;
  endtask

  task automatic test_line_wrap;
    logic [7:0] v39, v40;
    send_byte(0, 8'hA7); wait_ready;
    send_byte(1, "A"); wait_ready;
    send_byte(1, "B"); wait_ready;
    read_dd(39, v39); read_dd(40, v40);
    n_checks++;
    if ({v39, v40, ac} !== {8'h41, 8'h42, 7'h41})
      $display("FAIL wrap_inc: idx39=%h idx40=%h ac=%h, required 41 42 41", v39, v40, ac);
    else n_pass++;
    send_byte(0, 8'hC0); wait_ready;
    send_byte(0, 8'h04); wait_ready;
    send_byte(1, "C"); wait_ready;
    read_dd(40, v40);
    n_checks++;
    if ({v40, ac} !== {8'h43, 7'h27})
      $display("FAIL wrap_dec: idx40=%h ac=%h, required 43 27", v40, ac);
    else n_pass++;
    send_byte(0, 8'h06); wait_ready;
  endtask

  task automatic test_cgram;
    logic [4:0] g [3];
    send_byte(0, 8'h40); wait_ready;
    send_byte(1, 8'h1F); wait_ready;
    send_byte(1, 8'h11); wait_ready;
    send_byte(1, 8'h0A); wait_ready;
    for (int i = 0; i < 3; i++) read_cg(i, g[i]);
    n_checks++;
    if ({g[0], g[1], g[2], ac} !== {5'h1F, 5'h11, 5'h0A, 7'h03})
      $display("FAIL cgram_rows: got %h %h %h ac=%h, required 1F 11 0A ac=03", g[0], g[1], g[2], ac);
    else n_pass++;
  endtask

  task automatic test_4bit;
    int ch0, be0;
    logic [7:0] v;
    send_byte(0, 8'h28); wait_ready;
    send_byte(0, 8'h85); wait_ready;
    ch0 = c_char; be0 = c_berr;
    bus_write(1, 0, 8'h4A);
    n_checks++;
    if (c_char != ch0) $display("FAIL nibble_hi_no_strobe: char strobes %0d, required %0d", c_char, ch0);
    else n_pass++;
    bus_write(0, 1, 8'hFF);
    bus_write(1, 0, 8'h13);
    model_apply(1, 8'h41);
    wait_ready;
    read_dd(5, v);
    n_checks++;
    if ({c_char - ch0, v, ac} !== {32'd1, 8'h41, 7'h06})
      $display("FAIL nibble_byte: strobes=%0d idx5=%h ac=%h, required 1 41 06", c_char - ch0, v, ac);
    else n_pass++;
    n_checks++;
    if (c_berr != be0 + 1) $display("FAIL bus_err_read: got %0d pulses, required 1", c_berr - be0);
    else n_pass++;
    send_byte(0, 8'h38); wait_ready;
    n_checks++;
    if (mode_8bit !== 1'b1) $display("FAIL back_to_8bit: mode_8bit=%b, required 1", mode_8bit); else n_pass++;
  endtask

  task automatic test_timing;
    int t0, ch0;
    logic [7:0] v;
    t0 = c_terr; ch0 = c_char;
    send_byte(0, 8'h01);
    repeat (1) @(negedge clk);
    bus_write(1, 0, 8'h5A);
    n_checks++;
    if ({c_terr - t0, c_char - ch0} !== {32'd1, 32'd0})
      $display("FAIL fill_drop: timing_err=%0d char=%0d, required 1 0", c_terr - t0, c_char - ch0);
    else n_pass++;
    wait_ready;
    read_dd(0, v);
    n_checks++;
    if ({v, ac} !== {8'h20, 7'h00}) $display("FAIL fill_drop_data: idx0=%h ac=%h, required 20 00", v, ac);
    else n_pass++;
    t0 = c_terr;
    send_byte(0, 8'h0C);
    repeat (90) @(negedge clk);
    send_byte(1, 8'h59);
    n_checks++;
    if (c_terr - t0 != 1) $display("FAIL busy_overrun: timing_err=%0d, required 1", c_terr - t0); else n_pass++;
    wait_ready;
    read_dd(0, v);
    n_checks++;
    if ({v, ac} !== {8'h59, 7'h01}) $display("FAIL busy_overrun_data: idx0=%h ac=%h, required 59 01", v, ac);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] b, v;
    logic [4:0] g;
    logic [27:0] got, exp;
    bit rs;
    int k, bad, t0;
    t0 = c_terr;
    for (int n = 0; n < 180; n++) begin
      k = $urandom_range(0, 17);
      rs = 0;
      case (k)
        5, 6:  b = (m_two && $urandom_range(0, 3) != 0)
                   ? {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 39))}
                   : {1'b1, 7'($urandom)};
        7:     b = {2'b01, 6'($urandom)};
        8:     b = {3'b001, 5'($urandom)};
        9:     b = {4'b0001, 4'($urandom)};
        10:    b = {5'b00001, 3'($urandom)};
        11:    b = {6'b000001, 2'($urandom)};
        12:    b = {7'b0000001, 1'($urandom)};
        13:    b = ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00;
        default: begin rs = 1; b = 8'($urandom); end
      endcase
      send_byte(rs, b);
      wait_ready;
      got = {ac, two_line, mode_8bit, inc_mode, shift_mode, display_on, cursor_on, blink_on, display_shift, last_cmd};
      exp = {7'(m_ac), m_two, m_8bit, m_inc, m_smode, m_disp, m_cur, m_blink, 6'(m_shift), m_last};
      n_checks++;
      if (got !== exp) $display("FAIL rand_regs[%0d] op=%h rs=%b: got %h, required %h", n, b, rs, got, exp);
      else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin read_dd(i, v); if (v !== m_dd[i]) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL rand_ddram: %0d cells differ from model", bad); else n_pass++;
    bad = 0;
    for (int i = 0; i < 64; i++) if (m_cg_ok[i]) begin read_cg(i, g); if (g !== m_cg[i]) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL rand_cgram: %0d rows differ from model", bad); else n_pass++;
    n_checks++;
    if ({c_cmd, c_char, c_aerr} !== {e_cmd, e_char, e_aerr})
      $display("FAIL strobe_counts: cmd=%0d char=%0d aerr=%0d, required %0d %0d %0d", c_cmd, c_char, c_aerr, e_cmd, e_char, e_aerr);
    else n_pass++;
    n_checks++;
    if (c_terr != t0) $display("FAIL rand_no_timing_err: got %0d pulses, required 0", c_terr - t0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
    for (int i = 0; i < 64; i++) begin m_cg[i] = 5'h00; m_cg_ok[i] = 0; end
    test_reset;
    test_food;
    test_line_wrap;
    test_cgram;
    test_4bit;
    test_timing;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
